// File: rtl/linewin3x3.sv
// Streaming 3x3 window generator: two line memories plus a 3x3 shift window.
// Emits one window per pixel whose neighbourhood lies fully inside the frame.
module linewin3x3 #(
  parameter int D_BITS = 8,
  parameter int N      = 400
) (
  input  logic                  i_clk,
  input  logic                  reset,
  input  logic [31:0]           bleng,
  input  logic [D_BITS-1:0]     i_data,
  input  logic                  i_valid,
  output logic [9*D_BITS-1:0]   o_win,
  output logic                  o_valid,
  output logic                  o_frame_done
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0]        r_col;
  logic [1:0]           r_row;
  logic [31:0]          r_pix;
  logic [D_BITS-1:0]    r_lb1 [N];
  logic [D_BITS-1:0]    r_lb2 [N];
  logic [9*D_BITS-1:0]  r_win;

  logic [D_BITS-1:0]    w_lb1_rd, w_lb2_rd;
  logic [9*D_BITS-1:0]  w_win_nxt;
  logic                 w_col_last, w_frame_end, w_emit;

  assign w_lb1_rd    = r_lb1[r_col];
  assign w_lb2_rd    = r_lb2[r_col];
  assign w_col_last  = (r_col == CW'(N-1));
  assign w_frame_end = (bleng != 32'd0) && (r_pix == bleng - 32'd1);
  assign w_emit      = (r_row == 2'd2) && (r_col >= CW'(2));

  // Shift every row one column left; the new right column is the vertical slice at col.
  always_comb begin
    w_win_nxt = r_win;
    for (int r = 0; r < 3; r++) begin
      w_win_nxt[D_BITS*(3*r)   +: D_BITS] = r_win[D_BITS*(3*r+1) +: D_BITS];
      w_win_nxt[D_BITS*(3*r+1) +: D_BITS] = r_win[D_BITS*(3*r+2) +: D_BITS];
    end
    w_win_nxt[D_BITS*2 +: D_BITS] = w_lb2_rd;
    w_win_nxt[D_BITS*5 +: D_BITS] = w_lb1_rd;
    w_win_nxt[D_BITS*8 +: D_BITS] = i_data;
  end

  // Line memories are never cleared; stale rows are masked by the row gating.
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      r_lb2[r_col] <= w_lb1_rd;
      r_lb1[r_col] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_col        <= '0;
      r_row        <= '0;
      r_pix        <= '0;
      r_win        <= '0;
      o_win        <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_valid) begin
        r_win <= w_win_nxt;
        if (w_emit) begin
          o_valid <= 1'b1;
          o_win   <= w_win_nxt;
        end
        if (w_frame_end) begin
          o_frame_done <= 1'b1;
          r_col        <= '0;
          r_row        <= '0;
          r_pix        <= '0;
        end else begin
          r_pix <= r_pix + 32'd1;
          if (w_col_last) begin
            r_col <= '0;
            if (r_row != 2'd2) r_row <= r_row + 2'd1;
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
      end
    end
  end
endmodule

// File: doc/linewin3x3.md
# linewin3x3

Streaming 3x3 window generator that sits directly upstream of the image filter core, between the UART receiver and the filter arithmetic. It consumes the raw pixel byte stream produced by the UART receiver (one byte per `i_valid` strobe, raster order, fixed row width `N`). It emits one complete 3x3 neighbourhood per pixel whose window lies fully inside the image. Frame boundaries are tracked from the runtime frame length so consecutive images stream without a reset.

## Interface
- `D_BITS`, 8, pixel width in bits
- `N`, 400, image row width in pixels (>= 3)

- `i_clk`  in  1  system clock
- `reset`  in  1  one clock; reset is synchronous and active-high
- `bleng`  in  32  frame length in pixels (multiple of `N`); 0 = no frame limit; static during a frame
- `i_data`  in  D_BITS  incoming pixel
- `i_valid`  in  1  single-cycle strobe: `i_data` is a new pixel
- `o_win`  out  9*D_BITS  window; pixel (r,c) at `o_win[D_BITS*(3*r+c) +: D_BITS]`, r=0 oldest row, c=0 oldest column; centre = index 4
- `o_valid`  out  1  single-cycle strobe: `o_win` holds a new valid window
- `o_frame_done`  out  1  single-cycle strobe: last pixel of the frame accepted

## Operation
- Storage: two line memories of depth `N`, D_BITS wide: LB1 (previous row) and LB2 (row before that). Plus a 3x3 window register array.
- Counters:
  - `col` 0..N-1
  - `row`, saturating at 2 is sufficient
  - `pix` 32-bit pixels-in-frame
- On each `i_valid`, in the same cycle:
  - Read `LB2[col]` and `LB1[col]`.
  - Write `LB2[col] <= LB1[col]` and `LB1[col] <= i_data`.
  - Shift the window left one column.
  - New rightmost column (c=2) = {r0: `LB2[col]`, r1: `LB1[col]`, r2: `i_data`}.
- Counter update on `i_valid`:
  - `col` increments and wraps N-1 -> 0.
  - On wrap, `row` increments.
  - `pix` increments.
- Window emission: `o_valid` is asserted for the accepted pixel iff `row >= 2` and `col >= 2` at acceptance. Windows therefore never straddle a row boundary or include the top two rows.
- Frame end: applies when `bleng != 0` and the accepted pixel has `pix == bleng-1`.
  - `o_frame_done` pulses.
  - `col`, `row`, `pix` return to 0.
  - Line memories are not cleared; stale content is masked by row gating.
- `bleng == 0`: `pix` still counts (wraps at 2^32), no frame end, `o_frame_done` never asserts.
- Outputs per frame of R = bleng/N rows: exactly (R-2)*(N-2) windows.
- No backpressure: the consumer must accept every `o_valid`. `i_valid` may be asserted on consecutive cycles; the block must accept a pixel every cycle.
- `i_data` is ignored when `i_valid` = 0. `o_win` holds its last value between strobes.

## Timing
- Latency: `o_valid`, `o_win`, `o_frame_done` are registered, asserted the cycle after the `i_valid` that completes the window.
- Line-memory read and write at the same address in the same `i_valid` cycle: read returns the old contents (read-before-write).
- Reset values: `o_valid`=0, `o_frame_done`=0, `o_win`=0, all counters 0.
- Reset mid-frame: in-flight data is discarded. The first `i_valid` after reset deasserts is pixel (0,0) of a new frame. No `o_valid` is produced until row 2, col 2 of that frame.
- Frame-end pixel with `o_valid` condition true: `o_valid` and `o_frame_done` assert in the same cycle.
- Back-to-back frames: the pixel accepted the cycle after frame end is (0,0) of the next frame.

## Test plan
- N=4, bleng=16, pixels 0..15 back-to-back:
  - Exactly 4 `o_valid` pulses, one cycle after pixels 10, 11, 14, 15.
  - First window rows {0,1,2},{4,5,6},{8,9,10}, centre 5.
  - Last window centre 10.
  - `o_frame_done` coincides with the 4th pulse.
- Same frame with random 0-100 cycle gaps between strobes: identical window sequence, each one cycle after its completing strobe, `o_win` stable between pulses.
- Two frames back-to-back (values 0..15 then 100..115): frame 2 produces no output before its pixel 110. First frame-2 window is {100,101,102},{104,105,106},{108,109,110}, with no frame-1 data in it.
- Reset asserted after pixel 9 of a frame, then pixels 0..15: all outputs 0 during reset. Behaviour is identical to a clean first scenario.
- bleng=0, N=4, 24 pixels 0..23: windows after pixels 10, 11, 14, 15, 18, 19, 22, 23; `o_frame_done` never asserts.
- N=400, bleng=400*3, random data: exactly 398 windows. Each matches a reference model computed from the 3 rows.
